// File: rtl/cardinal_nic.sv
`default_nettype none
// ============================================================================
//  Module   : cardinal_nic
//  Purpose  : Register-mapped network interface between cardinal_processor
//             and the on-chip router. Holds a one-entry input channel buffer
//             (router -> processor) and a one-entry output channel buffer
//             (processor -> router). The processor polls the status
//             registers; there are no interrupts.
//  Ports    :
//    clk          in   system clock, all state on the rising edge
//    reset        in   asynchronous active-low reset
//    nic_addr     in   register select (0 in_buf, 1 in_status,
//                      2 out_buf, 3 out_status)
//    d_out        in   processor write data
//    nicEn        in   access enable
//    nicWrEn      in   1 = write, 0 = read (qualified by nicEn)
//    nic_data     out  processor read data (combinational)
//    net_si       in   router -> NIC send strobe
//    net_ri       out  NIC ready to accept from router
//    net_di       in   router -> NIC packet
//    net_so       out  NIC -> router send strobe
//    net_ro       in   router ready to accept from NIC
//    net_do       out  NIC -> router packet
//    net_polarity in   router cycle polarity (even/odd VC phase)
//  Bit order: data buses are [0:DATA_WIDTH-1]; bit 0 is the MSB and
//             carries the virtual-channel bit.
//  Revision : 1.0  initial release
// ============================================================================
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [0:ADDR_WIDTH-1]   nic_addr,
    input  logic [0:DATA_WIDTH-1]   d_out,
    input  logic                    nicEn,
    input  logic                    nicWrEn,
    output logic [0:DATA_WIDTH-1]   nic_data,
    input  logic                    net_si,
    output logic                    net_ri,
    input  logic [0:DATA_WIDTH-1]   net_di,
    output logic                    net_so,
    input  logic                    net_ro,
    output logic [0:DATA_WIDTH-1]   net_do,
    input  logic                    net_polarity
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_IN_BUF     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_IN_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_OUT_BUF    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_OUT_STATUS = ADDR_WIDTH'(3);

    logic [0:DATA_WIDTH-1] r_in_buf;
    logic                  r_in_full;
    logic [0:DATA_WIDTH-1] r_out_buf;
    logic                  r_out_full;

    logic w_rd;
    logic w_wr;
    logic w_rd_in_buf;
    logic w_wr_out_buf;
    logic w_accept;
    logic w_send;

    assign w_rd         = nicEn & ~nicWrEn;
    assign w_wr         = nicEn &  nicWrEn;
    assign w_rd_in_buf  = w_rd & (nic_addr == c_ADDR_IN_BUF);
    assign w_wr_out_buf = w_wr & (nic_addr == c_ADDR_OUT_BUF);

    // Ready is forced low while reset is held, even though the buffer is empty.
    assign net_ri   = reset & ~r_in_full;
    assign w_accept = net_si & net_ri;

    // Send only when the buffered packet's VC bit matches the current phase.
    assign w_send = r_out_full & net_ro & (r_out_buf[0] == net_polarity);
    assign net_so = w_send;
    assign net_do = r_out_buf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_buf   <= '0;
            r_in_full  <= 1'b0;
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else begin
            // Input channel. A receive can only coincide with an addr-0 read
            // when the buffer is empty (net_ri high), in which case the read
            // returns the stale contents and the new packet must stay valid.
            if (w_accept) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_rd_in_buf) begin
                r_in_full <= 1'b0;
            end

            // Output channel. A write seen while full is dropped even if the
            // buffer drains on this same edge.
            if (w_send) begin
                r_out_full <= 1'b0;
            end else if (w_wr_out_buf && !r_out_full) begin
                r_out_buf  <= d_out;
                r_out_full <= 1'b1;
            end
        end
    end

    always_comb begin
        nic_data = '0;
        if (reset && w_rd) begin
            case (nic_addr)
                c_ADDR_IN_BUF:     nic_data = r_in_buf;
                c_ADDR_IN_STATUS:  nic_data = {{(DATA_WIDTH-1){1'b0}}, r_in_full};
                c_ADDR_OUT_STATUS: nic_data = {{(DATA_WIDTH-1){1'b0}}, r_out_full};
                default:           nic_data = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cardinal_nic
//  Purpose  : Self-checking bench for cardinal_nic. A driver applies one
//             stimulus vector per cycle, advances a queue-based model of the
//             two channel buffers and pushes the expected outputs; a monitor
//             on the falling edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [2:0]  nic_addr;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic [63:0] nic_data;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    // Numeric [63:0] view: bit 63 here is the DUT's bit 0 (MSB / VC bit).
    cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .nic_addr     (nic_addr),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .nic_data     (nic_data),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ri;
        logic        so;
        logic [63:0] dv;
        logic [63:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] in_last;
    logic [63:0] out_last;
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // One cycle of stimulus plus the reference model step.
    task automatic drive(input logic rn, input logic pulse, input logic si, input logic [63:0] di,
                         input logic en, input logic wr, input logic [2:0] a, input logic [63:0] dout,
                         input logic ro, input logic pol);
        exp_t e;
        logic rd0;
        @(posedge clk);
        #1;
        reset        = rn;
        net_si       = si;
        net_di       = di;
        nicEn        = en;
        nicWrEn      = wr;
        nic_addr     = a;
        d_out        = dout;
        net_ro       = ro;
        net_polarity = pol;
        if (pulse) begin
            reset = 1'b0;
            #2;
            reset = 1'b1;
        end
        if (!rn || pulse) begin
            in_q.delete();
            out_q.delete();
            in_last  = '0;
            out_last = '0;
        end
        e = '0;
        if (rn) begin
            e.ri = (in_q.size() == 0);
            e.so = (out_q.size() == 1) && ro && (out_q[0][63] == pol);
            e.dv = out_last;
            if (en && !wr) begin
                case (a)
                    3'd0:    e.rd = in_last;
                    3'd1:    e.rd = 64'(in_q.size());
                    3'd3:    e.rd = 64'(out_q.size());
                    default: e.rd = '0;
                endcase
            end
            rd0 = en && !wr && (a == 3'd0);
            if (rd0 && in_q.size() != 0) void'(in_q.pop_front());
            if (si && e.ri) begin
                in_q.push_back(di);
                in_last = di;
            end
            if (en && wr && a == 3'd2 && out_q.size() == 0) begin
                out_q.push_back(dout);
                out_last = dout;
            end
            if (e.so) void'(out_q.pop_front());
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic ro, input logic pol);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0, ro, pol);
    endtask

    task automatic rd(input logic [2:0] a);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, a, '0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("net_ri", 64'(net_ri), 64'(e.ri));
            check("net_so", 64'(net_so), 64'(e.so));
            check("net_do", net_do, e.dv);
            check("nic_data", nic_data, e.rd);
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        in_last      = '0;
        out_last     = '0;
        reset        = 1'b0;
        net_si       = 1'b0;
        net_di       = '0;
        nicEn        = 1'b0;
        nicWrEn      = 1'b0;
        nic_addr     = '0;
        d_out        = '0;
        net_ro       = 1'b0;
        net_polarity = 1'b0;

        // Reset held three cycles, then status reads.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd1, '0, 1'b1, 1'b0);
        rd(3'd1);
        rd(3'd3);

        // Receive a packet, poll, drain, poll.
        drive(1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        rd(3'd1);
        rd(3'd0);
        rd(3'd1);
        rd(3'd0);  // empty read returns the stale packet

        // Output send gated by the VC phase.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd2, 64'h8000_0000_0000_00AA, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        rd(3'd3);

        // Back-to-back writes with the router stalled: second one dropped.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd2, 64'h0000_0000_0000_1111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd2, 64'h8000_0000_0000_2222, 1'b0, 1'b0);
        rd(3'd3);
        // Write while the buffer drains on the same edge is also dropped.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd2, 64'h0000_0000_0000_3333, 1'b1, 1'b0);
        rd(3'd3);

        // Receive, stale addr-0 read and send in one cycle.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd2, 64'h0000_0000_0000_4444, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_5555, 1'b1, 1'b0, 3'd0, '0, 1'b1, 1'b0);
        rd(3'd1);
        rd(3'd3);
        rd(3'd0);

        // Fill both buffers, then pulse reset between clock edges.
        drive(1'b1, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 3'd2, 64'h8000_0000_0000_6666, 1'b0, 1'b0);
        rd(3'd1);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 3'd1, '0, 1'b0, 1'b0);
        rd(3'd3);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] a;
            a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
